// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for the UART TX arbiter.
// The slave modport is the arbiter's view; master is the requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid_i;
  logic [N_REQ-1:0]   req_last_i;
  logic [8*N_REQ-1:0] req_byte_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic [N_REQ-1:0]   grant_o;
  logic               tx_start_o;
  logic [7:0]         tx_byte_o;
  logic               tx_ready_i;
  logic               busy_o;

  modport slave (
    input  req_valid_i, req_last_i, req_byte_i, tx_ready_i,
    output req_ready_o, grant_o, tx_start_o, tx_byte_o, busy_o
  );

  modport master (
    output req_valid_i, req_last_i, req_byte_i, tx_ready_i,
    input  req_ready_o, grant_o, tx_start_o, tx_byte_o, busy_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from N_REQ requesters into one UART transmitter.
// A packet (bytes up to req_last_i) is kept contiguous by locking onto its owner.
module uart_tx_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_IDLE = 2'd2
  } state_e;

  state_e             state_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   owner_r;
  logic               lock_r;
  logic [N_REQ-1:0]   ready_r;
  logic [N_REQ-1:0]   grant_r;
  logic               start_r;
  logic [7:0]         byte_r;
  logic               busy_r;

  logic [N_REQ-1:0]   eligible_s;
  logic               sel_valid_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic [IDX_W:0]     cand_s;
  logic [7:0]         sel_byte_s;
  logic               sel_last_s;
  logic [N_REQ-1:0]   sel_oh_s;

  // While locked only the packet owner may be picked, even if it stalls.
  always_comb begin
    if (lock_r) begin
      eligible_s = bus.req_valid_i & (ONE_HOT0 << owner_r);
    end else begin
      eligible_s = bus.req_valid_i;
    end
  end

  // Round-robin search starting one past the pointer, then mux the winner's byte.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    sel_byte_s  = 8'h00;
    sel_last_s  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s = {1'b0, ptr_r} + (IDX_W+1)'(i);
      if (cand_s >= (IDX_W+1)'(N_REQ)) begin
        cand_s = cand_s - (IDX_W+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!sel_valid_s && eligible_s[cand_s[IDX_W-1:0]]) begin
        sel_valid_s = 1'b1;
        sel_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_idx_s == IDX_W'(k)) begin
        sel_byte_s = bus.req_byte_i[8*k +: 8];
        sel_last_s = bus.req_last_i[k];
      end else begin
        sel_byte_s = sel_byte_s;
      end
    end
    sel_oh_s = ONE_HOT0 << sel_idx_s;
  end

  // Control FSM with all outputs and arbitration state registered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      ptr_r   <= IDX_W'(N_REQ - 1);
      owner_r <= '0;
      lock_r  <= 1'b0;
      ready_r <= '0;
      grant_r <= '0;
      start_r <= 1'b0;
      byte_r  <= 8'h00;
      busy_r  <= 1'b0;
    end else begin
      start_r <= 1'b0;
      ready_r <= '0;
      case (state_r)
        IDLE: begin
          if (bus.tx_ready_i && sel_valid_s) begin
            byte_r  <= sel_byte_s;
            start_r <= 1'b1;
            ready_r <= sel_oh_s;
            grant_r <= sel_oh_s;
            owner_r <= sel_idx_s;
            lock_r  <= !sel_last_s;
            if (sel_last_s) begin
              ptr_r <= sel_idx_s;
            end else begin
              ptr_r <= ptr_r;
            end
            busy_r  <= 1'b1;
            state_r <= WAIT_BUSY;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        WAIT_BUSY: begin
          busy_r <= 1'b1;
          if (!bus.tx_ready_i) begin
            state_r <= WAIT_IDLE;
          end else begin
            state_r <= WAIT_BUSY;
          end
        end
        WAIT_IDLE: begin
          if (bus.tx_ready_i) begin
            // The owner keeps its grant across the idle gap inside a packet.
            if (!lock_r) begin
              grant_r <= '0;
            end else begin
              grant_r <= grant_r;
            end
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= WAIT_IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          lock_r  <= 1'b0;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = ready_r;
  assign bus.grant_o     = grant_r;
  assign bus.tx_start_o  = start_r;
  assign bus.tx_byte_o   = byte_r;
  assign bus.busy_o      = busy_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a UART transmitter
// model that goes busy for three cycles per byte, and a start-pulse log.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] qmem [N][32];
  int         qhead [N];
  int         qtail [N];
  logic [3:0] stall = 4'b0000;
  logic       force_busy = 1'b0;
  int         busy_cnt = 0;

  int         log_idx  [256];
  logic [7:0] log_byte [256];
  int         n_log = 0;
  logic       saw_idle = 1'b1;
  logic [7:0] last_byte = 8'h00;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] order;
    int          cnt;
  } vec_t;
  vec_t tv [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter, requester and monitor models, all acting on the falling edge.
  initial begin
    for (int k = 0; k < N; k++) begin
      qhead[k] = 0;
      qtail[k] = 0;
    end
    bus.tx_ready_i  = 1'b1;
    bus.req_valid_i = '0;
    bus.req_last_i  = '0;
    bus.req_byte_i  = '0;
    forever begin
      @(negedge clk);
      if (bus.tx_start_o) begin
        int idx;
        idx = 0;
        for (int k = 0; k < N; k++) if (bus.req_ready_o[k]) idx = k;
        check("ready_onehot", 32'($onehot(bus.req_ready_o)), 32'd1);
        check("grant_eq_ready", bus.grant_o, bus.req_ready_o);
        if (n_log > 0) check("idle_between_starts", saw_idle, 1'b1);
        saw_idle = 1'b0;
        last_byte = bus.tx_byte_o;
        log_idx[n_log]  = idx;
        log_byte[n_log] = bus.tx_byte_o;
        n_log++;
      end else if (bus.busy_o) begin
        check("tx_byte_hold", bus.tx_byte_o, last_byte);
      end
      if (!bus.busy_o) saw_idle = 1'b1;
      if (busy_cnt > 0) busy_cnt--;
      if (bus.tx_start_o) busy_cnt = 3;
      bus.tx_ready_i = (busy_cnt == 0) && !force_busy;
      for (int k = 0; k < N; k++) begin
        if (bus.req_ready_o[k] && qhead[k] < qtail[k]) qhead[k]++;
        bus.req_valid_i[k] = (qhead[k] < qtail[k]) && !stall[k];
        bus.req_byte_i[8*k +: 8] = (qhead[k] < qtail[k]) ? qmem[k][qhead[k]][7:0] : 8'h00;
        bus.req_last_i[k] = (qhead[k] < qtail[k]) ? qmem[k][qhead[k]][8] : 1'b0;
      end
    end
  end

  task automatic push(input int k, input logic [7:0] b, input logic last);
    qmem[k][qtail[k]] = {last, b};
    qtail[k]++;
  endtask

  task automatic wait_log(input int n, input int budget);
    int c;
    c = 0;
    while (n_log < n && c < budget) begin
      @(negedge clk); #2;
      c++;
    end
    check("log_count", n_log, n);
  endtask

  task automatic wait_quiet(input int budget);
    int c;
    logic q;
    c = 0;
    q = 1'b0;
    while (!q && c < budget) begin
      @(negedge clk); #2;
      c++;
      q = !bus.busy_o && bus.tx_ready_i;
      for (int k = 0; k < N; k++) if (qhead[k] < qtail[k]) q = 1'b0;
    end
    check("quiet_timeout", q, 1'b1);
  endtask

  task automatic expect_entry(input string name, input int i, input int idx, input logic [7:0] b);
    check({name, "_idx"}, log_idx[i], idx);
    check({name, "_byte"}, log_byte[i], b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    tv[0] = '{4'b0110, 16'h0021, 2};
    tv[1] = '{4'b1001, 16'h0003, 2};
    tv[2] = '{4'b0001, 16'h0000, 1};
    tv[3] = '{4'b1111, 16'h0321, 4};
    tv[4] = '{4'b0101, 16'h0002, 2};
    tv[5] = '{4'b1000, 16'h0003, 1};
    tv[6] = '{4'b0011, 16'h0010, 2};

    repeat (3) @(negedge clk);
    #2;
    check("rst_tx_start", bus.tx_start_o, 1'b0);
    check("rst_tx_byte", bus.tx_byte_o, 8'h00);
    check("rst_ready", bus.req_ready_o, 4'b0000);
    check("rst_grant", bus.grant_o, 4'b0000);
    check("rst_busy", bus.busy_o, 1'b0);
    @(negedge clk);
    reset_i = 1'b0;

    // Single byte from requester 0 right after reset.
    push(0, 8'hA5, 1'b1);
    wait_log(1, 50);
    check("a5_start", bus.tx_start_o, 1'b1);
    check("a5_byte", bus.tx_byte_o, 8'hA5);
    check("a5_ready", bus.req_ready_o, 4'b0001);
    check("a5_grant", bus.grant_o, 4'b0001);
    check("a5_busy", bus.busy_o, 1'b1);
    @(negedge clk); #2;
    check("a5_start_pulse", bus.tx_start_o, 1'b0);
    check("a5_ready_pulse", bus.req_ready_o, 4'b0000);
    check("a5_byte_held", bus.tx_byte_o, 8'hA5);
    wait_quiet(100);
    check("a5_grant_clear", bus.grant_o, 4'b0000);

    // Round-robin vectors; pointer history carries from one vector to the next.
    for (int v = 0; v < 7; v++) begin
      base = n_log;
      for (int k = 0; k < N; k++) if (tv[v].mask[k]) push(k, 8'(16*v + k), 1'b1);
      wait_log(base + tv[v].cnt, 200);
      for (int j = 0; j < tv[v].cnt; j++) begin
        expect_entry("rr_vec", base + j, int'(tv[v].order[4*j +: 4]), 8'(16*v + int'(tv[v].order[4*j +: 4])));
      end
      wait_quiet(100);
    end

    // All four continuously valid after reset: 0,1,2,3,0,1.
    @(negedge clk); reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    #2;
    base = n_log;
    push(0, 8'h80, 1'b1); push(0, 8'h84, 1'b1);
    push(1, 8'h81, 1'b1); push(1, 8'h85, 1'b1);
    push(2, 8'h82, 1'b1); push(3, 8'h83, 1'b1);
    wait_log(base + 6, 300);
    for (int j = 0; j < 6; j++) expect_entry("all_valid", base + j, j % 4, 8'(8'h80 + j));
    wait_quiet(100);

    // Three-byte packet from requester 1 stays contiguous while requester 2 waits.
    push(0, 8'h90, 1'b1);
    wait_log(n_log + 1, 50);
    wait_quiet(100);
    base = n_log;
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
    push(2, 8'h77, 1'b1);
    wait_log(base + 4, 300);
    expect_entry("pkt_b0", base + 0, 1, 8'h11);
    expect_entry("pkt_b1", base + 1, 1, 8'h22);
    expect_entry("pkt_b2", base + 2, 1, 8'h33);
    expect_entry("pkt_next", base + 3, 2, 8'h77);
    wait_quiet(100);

    // Locked owner 0 stalls for 20 cycles; requester 3 must not be served meanwhile.
    base = n_log;
    push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b0); push(0, 8'hC3, 1'b1);
    wait_log(base + 1, 50);
    stall[0] = 1'b1;
    push(3, 8'hD3, 1'b1);
    repeat (20) begin @(negedge clk); #2; end
    check("stall_no_start", n_log, base + 1);
    check("stall_grant_held", bus.grant_o, 4'b0001);
    stall[0] = 1'b0;
    wait_log(base + 4, 300);
    expect_entry("stall_b0", base + 0, 0, 8'hC1);
    expect_entry("stall_b1", base + 1, 0, 8'hC2);
    expect_entry("stall_b2", base + 2, 0, 8'hC3);
    expect_entry("stall_other", base + 3, 3, 8'hD3);
    wait_quiet(100);

    // Transmitter busy for 100 cycles with requester 2 pending.
    force_busy = 1'b1;
    @(negedge clk); #2;
    base = n_log;
    push(2, 8'hE2, 1'b1);
    repeat (100) begin @(negedge clk); #2; end
    check("txbusy_no_start", n_log, base);
    force_busy = 1'b0;
    @(negedge clk); #2;
    check("txbusy_release_ready", bus.tx_ready_i, 1'b1);
    check("txbusy_not_yet", n_log, base);
    @(negedge clk); #2;
    check("txbusy_start_next", n_log, base + 1);
    expect_entry("txbusy_entry", base, 2, 8'hE2);
    wait_quiet(100);

    // Reset in WAIT_IDLE of a locked packet; requester 0 then has priority.
    base = n_log;
    push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b1);
    wait_log(base + 1, 50);
    push(0, 8'h60, 1'b1); push(3, 8'h63, 1'b1);
    @(negedge clk); #2;
    check("pre_rst_busy", bus.busy_o, 1'b1);
    check("pre_rst_grant", bus.grant_o, 4'b0010);
    reset_i = 1'b1;
    #1;
    check("mid_rst_tx_start", bus.tx_start_o, 1'b0);
    check("mid_rst_tx_byte", bus.tx_byte_o, 8'h00);
    check("mid_rst_ready", bus.req_ready_o, 4'b0000);
    check("mid_rst_grant", bus.grant_o, 4'b0000);
    check("mid_rst_busy", bus.busy_o, 1'b0);
    qhead[1] = qtail[1];
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    wait_log(base + 2, 100);
    expect_entry("post_rst_first", base + 1, 0, 8'h60);
    wait_log(base + 3, 100);
    expect_entry("post_rst_second", base + 2, 3, 8'h63);
    wait_quiet(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (legal range 2..8).
REQ-002 The block SHALL have port clk_i  input  1  system clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port req_valid_i  input  N_REQ  per-requester byte-available flag.
REQ-005 The block SHALL have port req_last_i  input  N_REQ  per-requester flag marking the final byte of a packet.
REQ-006 The block SHALL have port req_byte_i  input  8*N_REQ  requester k byte at bits [8k+7:8k].
REQ-007 The block SHALL have port req_ready_o  output  N_REQ  one-hot, one-cycle accept pulse.
REQ-008 The block SHALL have port grant_o  output  N_REQ  one-hot current owner; all zero when no owner.
REQ-009 The block SHALL have port tx_start_o  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 The block SHALL have port tx_byte_o  output  8  byte to transmit, held stable from start until the transmitter returns idle.
REQ-011 The block SHALL have port tx_ready_i  input  1  transmitter idle (high) / busy (low).
REQ-012 The block SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT_BUSY and WAIT_IDLE, with all outputs registered.
REQ-014 In IDLE with tx_ready_i=1 and an eligible requester, the arbiter SHALL, on the next edge, select one requester k, load tx_byte_o with req_byte_i[k], pulse tx_start_o and req_ready_o[k] for exactly one cycle, set grant_o to one-hot k, and enter WAIT_BUSY.
REQ-015 Requester k SHALL hold valid, byte and last stable until it sees req_ready_o[k]=1, and MAY change them on the edge ending that cycle.
REQ-016 Eligibility when unlocked: every requester with req_valid_i=1.
REQ-017 Selection when unlocked SHALL be round-robin, searching from (pointer+1) mod N_REQ upward with wrap, picking the first eligible requester.
REQ-018 Eligibility when locked: only the owner, and only when its req_valid_i=1; other requesters SHALL NOT be served even if the owner stalls indefinitely.
REQ-019 Lock SHALL be set on capture of a byte with req_last_i=0 and cleared on capture of a byte with req_last_i=1.
REQ-020 On capture of a last byte, pointer SHALL be set to the owner index, and grant_o SHALL clear on the WAIT_IDLE->IDLE transition.
REQ-021 WAIT_BUSY SHALL transition to WAIT_IDLE when tx_ready_i=0; tx_start_o SHALL be low in this state.
REQ-022 WAIT_IDLE SHALL transition to IDLE when tx_ready_i=1.
REQ-023 When IDLE sees tx_ready_i=0, no selection SHALL occur and pending requests SHALL wait.
REQ-024 There SHALL be no back-to-back issue: at least one IDLE cycle SHALL occur between consecutive tx_start_o pulses.
REQ-025 req_valid_i changes on non-selected requesters SHALL have no effect until the next IDLE evaluation.

Reset
REQ-026 On reset_i=1, the block SHALL immediately enter IDLE and set tx_start_o=0, tx_byte_o=8'h00, req_ready_o=0, grant_o=0, busy_o=0, lock=0 and pointer=N_REQ-1, so that requester 0 has first priority.
REQ-027 Reset mid-packet or mid-byte SHALL abandon the packet; no state SHALL survive reset.

Verification
REQ-028 The bench SHALL cover: after reset, req0 valid, byte 0xA5, last=1 -> tx_start_o pulse with tx_byte_o=0xA5, req_ready_o=0001 pulse, grant_o=0000 after transmitter idle.
REQ-029 The bench SHALL cover: all four requesters continuously valid with single-byte packets (last=1) -> grant order 0,1,2,3,0,1.
REQ-030 The bench SHALL cover: req1 sends a 3-byte packet 0x11,0x22,0x33 (last on 0x33) while req2 is valid -> bytes 0x11,0x22,0x33 issued contiguously, then req2.
REQ-031 The bench SHALL cover: locked owner req0 drops valid for 20 cycles mid-packet while req3 is valid -> no tx_start_o for req3 until req0's last byte is issued.
REQ-032 The bench SHALL cover: tx_ready_i held low 100 cycles with req2 pending -> no tx_start_o; start occurs on the cycle after tx_ready_i returns high.
REQ-033 The bench SHALL cover: reset_i asserted in WAIT_IDLE of a locked packet -> all outputs zero immediately, and the next grant goes to requester 0 if it is valid.
